en2_pulse_gen: RTL and testbench



---
 rtl/en2_pulse_gen.sv | 153 +++++++++++++++
 tb/tb_en2_pulse_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/en2_pulse_gen.sv
// Turns single-cycle request strobes into fixed-width pulses with a minimum low gap, queueing up to PEND_MAX requests.
// Optional EN2_PULSE_GEN_SYNC_EN: treat en as an async level, synchronize it and count rising edges (+2 cycles latency).
module en2_pulse_gen #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 1,
    parameter int PEND_MAX = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic                          out,
    output logic                          start,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pend,
    output logic                          drop
);
    localparam int PW   = $clog2(PEND_MAX + 1);
    localparam int MAXC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    generate
        if (HIGH_CYC < 1) begin : g_bad_high
            $error("en2_pulse_gen: HIGH_CYC must be >= 1");
        end
        if (LOW_CYC < 1) begin : g_bad_low
            $error("en2_pulse_gen: LOW_CYC must be >= 1");
        end
        if (PEND_MAX < 1) begin : g_bad_pend
            $error("en2_pulse_gen: PEND_MAX must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    logic req;

`ifdef EN2_PULSE_GEN_SYNC_EN
    logic en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_prev_q, en_prev_d;

    always_comb begin
        en_s1_d   = en;
        en_s2_d   = en_s1_q;
        en_prev_d = en_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            en_s1_q   <= en_s1_d;
            en_s2_q   <= en_s2_d;
            en_prev_q <= en_prev_d;
        end
    end

    // one request per rising edge of the synchronized level
    assign req = en_s2_q & ~en_prev_q;
`else
    assign req = en;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic            out_q, out_d;
    logic            start_q, start_d;
    logic            drop_q, drop_d;
    logic            last_cyc;
    logic            full;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        drop_d   = 1'b0;
        last_cyc = (cnt_q == CW'(1));
        full     = (pend_q == PW'(PEND_MAX));

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = HIGH;
                    cnt_d   = CW'(HIGH_CYC);
                end
            end
            HIGH: begin
                if (req) begin
                    if (full) drop_d = 1'b1;
                    else      pend_d = pend_q + PW'(1);
                end
                if (last_cyc) begin
                    state_d = GAP;
                    cnt_d   = CW'(LOW_CYC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (last_cyc) begin
                    // a same-cycle request replaces the one consumed, so the queue never overflows here
                    if ((pend_q != '0) || req) begin
                        state_d = HIGH;
                        cnt_d   = CW'(HIGH_CYC);
                        if ((pend_q != '0) && !req) pend_d = pend_q - PW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    if (req) begin
                        if (full) drop_d = 1'b1;
                        else      pend_d = pend_q + PW'(1);
                    end
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        out_d   = (state_d == HIGH);
        start_d = (state_d == HIGH) && (state_q != HIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

    assign out   = out_q;
    assign start = start_q;
    assign drop  = drop_q;
    assign busy  = (state_q != IDLE);
    assign pend  = pend_q;

endmodule

// File: tb/tb_en2_pulse_gen.sv
// Bench for en2_pulse_gen: start-time scheduling model compared every cycle, plus literal directed scenarios.
module tb_en2_pulse_gen;
    localparam int H  = 4;
    localparam int L  = 2;
    localparam int PM = 2;
    localparam int P  = H + L;
    localparam int PW = $clog2(PM + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          out, start, busy, drop;
    logic [PW-1:0] pend;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    en2_pulse_gen #(.HIGH_CYC(H), .LOW_CYC(L), .PEND_MAX(PM)) dut (
        .clk(clk), .rst(rst), .en(en), .out(out), .start(start),
        .busy(busy), .pend(pend), .drop(drop)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: list of absolute pulse start edges; a pulse at s is high on edges s..s+H-1, busy to s+P-1.
    int q[$];
    int cyc, last_start, n_future;
    bit have_last, req;
    bit s1, s2, pv;
    bit m_out, m_start, m_busy, m_drop;
    int m_pend;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            cyc = 0; have_last = 0; last_start = 0;
            s1 = 0; s2 = 0; pv = 0;
            m_out = 0; m_start = 0; m_busy = 0; m_drop = 0; m_pend = 0;
        end else begin
            cyc++;
`ifdef EN2_PULSE_GEN_SYNC_EN
            req = s2 && !pv;
            pv = s2; s2 = s1; s1 = en;
`else
            req = en;
`endif
            n_future = 0;
            foreach (q[i]) if (q[i] > cyc) n_future++;
            m_drop = 0;
            if (req) begin
                if (!have_last || last_start + P <= cyc) begin
                    last_start = cyc; have_last = 1; q.push_back(cyc);
                end else if (n_future < PM) begin
                    last_start += P; q.push_back(last_start);
                end else begin
                    m_drop = 1;
                end
            end
            m_out = 0; m_start = 0; m_pend = 0;
            foreach (q[i]) begin
                if (q[i] <= cyc && cyc < q[i] + H) m_out = 1;
                if (q[i] == cyc) m_start = 1;
                if (q[i] > cyc) m_pend++;
            end
            m_busy = have_last && (cyc < last_start + P);
            while (q.size() > 0 && q[0] + P <= cyc) void'(q.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            chk("m_out", int'(out), int'(m_out));
            chk("m_start", int'(start), int'(m_start));
            chk("m_busy", int'(busy), int'(m_busy));
            chk("m_pend", int'(pend), m_pend);
            chk("m_drop", int'(drop), int'(m_drop));
        end
    end

    int nst, first_st, ep;
    int pct [6] = '{8, 30, 55, 80, 100, 20};

    initial begin
        en  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_drop", int'(drop), 0);
        rst = 1'b0;
        cmp_on = 1'b1;
        repeat (3) @(negedge clk);

`ifndef EN2_PULSE_GEN_SYNC_EN
        // single request: high 4 cycles, busy 6
        for (int k = 0; k < 8; k++) begin
            en = (k == 0);
            @(negedge clk);
            chk("single_out", int'(out), int'(k < 4));
            chk("single_start", int'(start), int'(k == 0));
            chk("single_busy", int'(busy), int'(k < 6));
        end

        // four back-to-back requests: one dropped, pulses at 0, 6, 12
        nst = 0;
        for (int k = 0; k < 20; k++) begin
            en = (k < 4);
            @(negedge clk);
            ep = (k == 0) ? 0 : (k == 1) ? 1 : (k < 6) ? 2 : (k < 12) ? 1 : 0;
            if (start) nst++;
            chk("ovf_start", int'(start), int'(k == 0 || k == 6 || k == 12));
            chk("ovf_pend", int'(pend), ep);
            chk("ovf_drop", int'(drop), int'(k == 3));
        end
        chk("ovf_pulses", nst, 3);

        // request on the last gap cycle with a full queue
        for (int k = 0; k < 26; k++) begin
            en = (k < 3) || (k == 6);
            @(negedge clk);
            ep = (k == 0) ? 0 : (k == 1) ? 1 : (k < 12) ? 2 : (k < 18) ? 1 : 0;
            chk("gap_start", int'(start), int'(k == 0 || k == 6 || k == 12 || k == 18));
            chk("gap_pend", int'(pend), ep);
            chk("gap_drop", int'(drop), 0);
        end
`endif

        // en held for 3 cycles
        nst = 0;
        first_st = -1;
        for (int k = 0; k < 30; k++) begin
            en = (k < 3);
            @(negedge clk);
            if (start) begin
                nst++;
                if (first_st < 0) first_st = k;
            end
        end
`ifdef EN2_PULSE_GEN_SYNC_EN
        chk("held_pulses", nst, 1);
        chk("held_first", first_st, 2);
`else
        chk("held_pulses", nst, 3);
        chk("held_first", first_st, 0);
`endif

`ifndef EN2_PULSE_GEN_SYNC_EN
        // asynchronous reset mid-HIGH with one request queued
        for (int k = 0; k < 3; k++) begin
            en = (k < 2);
            @(negedge clk);
        end
        chk("pre_rst_out", int'(out), 1);
        chk("pre_rst_pend", int'(pend), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_pend", int'(pend), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_out", int'(out), 0);
            chk("post_rst_pend", int'(pend), 0);
        end
`endif

        // random traffic at several densities, with one reset in flight
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 300; c++) begin
                if (s == 3 && c == 150) rst = 1'b1;
                if (s == 3 && c == 152) rst = 1'b0;
                en = ($urandom_range(0, 99) < pct[s]);
                @(negedge clk);
            end
        end
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("drain_busy", int'(busy), 0);
        chk("drain_pend", int'(pend), 0);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
